// File: rtl/issue_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// issue_scheduler_pkg
//   Shared constants and types for the issue scheduler slice.
//   NB_REG / REG_W size the register scoreboard and every register index in
//   the queue-head interface and the issue slot. NB_UNIT is the number of
//   issue queues / execution units (arithm, branch, lsu).
//   unit_e is the one-hot unit code driven on issue_unit_o.
//   unit_idx_e is the binary queue index used by the round-robin pointer.
// -----------------------------------------------------------------------------
package issue_scheduler_pkg;

    localparam int NB_REG  = 32;
    localparam int REG_W   = $clog2(NB_REG);
    localparam int NB_UNIT = 3;

    typedef enum logic [NB_UNIT-1:0] {
        UNIT_NONE   = 3'b000,
        UNIT_ARITHM = 3'b001,
        UNIT_BRANCH = 3'b010,
        UNIT_LSU    = 3'b100
    } unit_e;

    typedef enum logic [1:0] {
        IDX_ARITHM = 2'd0,
        IDX_BRANCH = 2'd1,
        IDX_LSU    = 2'd2
    } unit_idx_e;

    // Round-robin successor: arithm -> branch -> lsu -> arithm.
    function automatic unit_idx_e next_idx(input unit_idx_e idx);
        case (idx)
            IDX_ARITHM: return IDX_BRANCH;
            IDX_BRANCH: return IDX_LSU;
            default:    return IDX_ARITHM;
        endcase
    endfunction

    function automatic unit_e idx_to_unit(input unit_idx_e idx);
        case (idx)
            IDX_ARITHM: return UNIT_ARITHM;
            IDX_BRANCH: return UNIT_BRANCH;
            default:    return UNIT_LSU;
        endcase
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// -----------------------------------------------------------------------------
// issue_scheduler_if
//   One issue-queue head as seen by the scheduler. One instance per queue.
//   v              head valid
//   rs1_v / rs1    head reads rs1 / rs1 index
//   rs2_v / rs2    head reads rs2 / rs2 index
//   rd_v  / rd     head writes rd / rd index
//   ready          pop: head granted this cycle (combinational from scheduler)
//   master = issue queue side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface issue_scheduler_if;
    import issue_scheduler_pkg::*;

    logic             v;
    logic             rs1_v;
    logic [REG_W-1:0] rs1;
    logic             rs2_v;
    logic [REG_W-1:0] rs2;
    logic             rd_v;
    logic [REG_W-1:0] rd;
    logic             ready;

    modport master (
        output v, rs1_v, rs1, rs2_v, rs2, rd_v, rd,
        input  ready
    );

    modport slave (
        input  v, rs1_v, rs1, rs2_v, rs2, rd_v, rd,
        output ready
    );

endinterface

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//   Busy bit per architectural register. A bit is set when an op that writes
//   it is granted and cleared by writeback. x0 is never busy.
//   Ports:
//     clk, reset_n        clock, asynchronous active-low reset
//     set_v_i / set_rd_i  granted op writes set_rd_i
//     clr_v_i / clr_rd_i  writeback of clr_rd_i
//     rs1_i/rs2_i/rd_i    register indices of the three queue heads
//     rs1_busy_o ...      per-head hazard flags; a writeback in the same
//                         cycle already counts as free (bypass)
// -----------------------------------------------------------------------------
module issue_scoreboard (
    input  logic                                                        clk,
    input  logic                                                        reset_n,
    input  logic                                                        set_v_i,
    input  logic [issue_scheduler_pkg::REG_W-1:0]                       set_rd_i,
    input  logic                                                        clr_v_i,
    input  logic [issue_scheduler_pkg::REG_W-1:0]                       clr_rd_i,
    input  logic [issue_scheduler_pkg::NB_UNIT-1:0][issue_scheduler_pkg::REG_W-1:0] rs1_i,
    input  logic [issue_scheduler_pkg::NB_UNIT-1:0][issue_scheduler_pkg::REG_W-1:0] rs2_i,
    input  logic [issue_scheduler_pkg::NB_UNIT-1:0][issue_scheduler_pkg::REG_W-1:0] rd_i,
    output logic [issue_scheduler_pkg::NB_UNIT-1:0]                     rs1_busy_o,
    output logic [issue_scheduler_pkg::NB_UNIT-1:0]                     rs2_busy_o,
    output logic [issue_scheduler_pkg::NB_UNIT-1:0]                     rd_busy_o
);
    import issue_scheduler_pkg::*;

    logic [NB_REG-1:0] busy_q, busy_d;
    logic [NB_REG-1:0] set_mask, clr_mask;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        // x0 is hard-wired free: neither a set nor a clear of it is recorded.
        if (set_v_i && (set_rd_i != '0)) set_mask[set_rd_i] = 1'b1;
        if (clr_v_i && (clr_rd_i != '0)) clr_mask[clr_rd_i] = 1'b1;
        // Set applied after clear: a new writer of the same register wins.
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    // A register counts as free when its bit is clear or it is being
    // written back this very cycle.
    always_comb begin
        for (int u = 0; u < NB_UNIT; u++) begin
            rs1_busy_o[u] = busy_q[rs1_i[u]] & ~clr_mask[rs1_i[u]];
            rs2_busy_o[u] = busy_q[rs2_i[u]] & ~clr_mask[rs2_i[u]];
            rd_busy_o[u]  = busy_q[rd_i[u]]  & ~clr_mask[rd_i[u]];
        end
    end

    // NOTE: the busy vector is a bank of flops, not a RAM, so it is reset
    // like any other state: after reset nothing may look outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignment for state, so every flop samples
            // pre-edge values regardless of process evaluation order.
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//   Picks at most one instruction per cycle from the arithm, branch and lsu
//   queue heads, blocks RAW/WAW hazards via issue_scoreboard, rotates priority
//   among eligible queues and loads the winner into a registered issue slot.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     arithm_if/branch_if/lsu_if   queue heads (slave), ready = pop
//     exe_ready_i                  exe stage accepts the issue slot
//     wb_v_i / wb_rd_i             writeback, clears scoreboard bit
//     lsu_busy_i                   LSU cannot take a new op
//     branch_done_i                outstanding branch resolved
//     flush_i                      mispredict flush of the issue slot
//     issue_v_o                    issue slot valid
//     issue_unit_o                 one-hot {lsu,branch,arithm}
//     issue_rd_v_o/issue_rd_o      issued destination
//     issue_rs1_o/issue_rs2_o      issued sources
//   Register widths come from issue_scheduler_pkg (NB_REG, REG_W).
// -----------------------------------------------------------------------------
module issue_scheduler (
    input  logic                                      clk,
    input  logic                                      reset_n,
    issue_scheduler_if.slave                          arithm_if,
    issue_scheduler_if.slave                          branch_if,
    issue_scheduler_if.slave                          lsu_if,
    input  logic                                      exe_ready_i,
    input  logic                                      wb_v_i,
    input  logic [issue_scheduler_pkg::REG_W-1:0]     wb_rd_i,
    input  logic                                      lsu_busy_i,
    input  logic                                      branch_done_i,
    input  logic                                      flush_i,
    output logic                                      issue_v_o,
    output logic [issue_scheduler_pkg::NB_UNIT-1:0]   issue_unit_o,
    output logic                                      issue_rd_v_o,
    output logic [issue_scheduler_pkg::REG_W-1:0]     issue_rd_o,
    output logic [issue_scheduler_pkg::REG_W-1:0]     issue_rs1_o,
    output logic [issue_scheduler_pkg::REG_W-1:0]     issue_rs2_o
);
    import issue_scheduler_pkg::*;

    // Queue heads flattened into arrays indexed by unit_idx_e.
    logic [NB_UNIT-1:0]            head_v, head_rs1_v, head_rs2_v, head_rd_v;
    logic [NB_UNIT-1:0][REG_W-1:0] head_rs1, head_rs2, head_rd;

    always_comb begin
        head_v[IDX_ARITHM]     = arithm_if.v;
        head_rs1_v[IDX_ARITHM] = arithm_if.rs1_v;
        head_rs1[IDX_ARITHM]   = arithm_if.rs1;
        head_rs2_v[IDX_ARITHM] = arithm_if.rs2_v;
        head_rs2[IDX_ARITHM]   = arithm_if.rs2;
        head_rd_v[IDX_ARITHM]  = arithm_if.rd_v;
        head_rd[IDX_ARITHM]    = arithm_if.rd;

        head_v[IDX_BRANCH]     = branch_if.v;
        head_rs1_v[IDX_BRANCH] = branch_if.rs1_v;
        head_rs1[IDX_BRANCH]   = branch_if.rs1;
        head_rs2_v[IDX_BRANCH] = branch_if.rs2_v;
        head_rs2[IDX_BRANCH]   = branch_if.rs2;
        head_rd_v[IDX_BRANCH]  = branch_if.rd_v;
        head_rd[IDX_BRANCH]    = branch_if.rd;

        head_v[IDX_LSU]        = lsu_if.v;
        head_rs1_v[IDX_LSU]    = lsu_if.rs1_v;
        head_rs1[IDX_LSU]      = lsu_if.rs1;
        head_rs2_v[IDX_LSU]    = lsu_if.rs2_v;
        head_rs2[IDX_LSU]      = lsu_if.rs2;
        head_rd_v[IDX_LSU]     = lsu_if.rd_v;
        head_rd[IDX_LSU]       = lsu_if.rd;
    end

    // State
    logic             issue_v_q,    issue_v_d;
    logic [NB_UNIT-1:0] issue_unit_q, issue_unit_d;
    logic             issue_rd_v_q, issue_rd_v_d;
    logic [REG_W-1:0] issue_rd_q,   issue_rd_d;
    logic [REG_W-1:0] issue_rs1_q,  issue_rs1_d;
    logic [REG_W-1:0] issue_rs2_q,  issue_rs2_d;
    unit_idx_e        rr_ptr_q,     rr_ptr_d;
    logic             branch_pending_q, branch_pending_d;

    // Scoreboard
    logic [NB_UNIT-1:0] rs1_busy, rs2_busy, rd_busy;
    logic               sb_set_v;
    logic [REG_W-1:0]   sb_set_rd;

    issue_scoreboard u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_v_i    (sb_set_v),
        .set_rd_i   (sb_set_rd),
        .clr_v_i    (wb_v_i),
        .clr_rd_i   (wb_rd_i),
        .rs1_i      (head_rs1),
        .rs2_i      (head_rs2),
        .rd_i       (head_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

    // Eligibility
    logic [NB_UNIT-1:0] eligible;

    always_comb begin
        for (int u = 0; u < NB_UNIT; u++) begin
            eligible[u] = head_v[u]
                        & ~(head_rs1_v[u] & rs1_busy[u])
                        & ~(head_rs2_v[u] & rs2_busy[u])
                        & ~(head_rd_v[u]  & rd_busy[u]);
        end
        eligible[IDX_LSU]    = eligible[IDX_LSU]    & ~lsu_busy_i;
        eligible[IDX_BRANCH] = eligible[IDX_BRANCH] & ~branch_pending_q;
    end

    // Rotating arbiter
    // The slot can take a new op when it is empty or being drained this cycle.
    logic               slot_free;
    logic               grant_any;
    unit_idx_e          win_idx;
    unit_idx_e          cand;
    logic [NB_UNIT-1:0] grant;

    assign slot_free = ~issue_v_q | exe_ready_i;

    always_comb begin
        grant_any = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        if (slot_free && !flush_i) begin
            // Scan from rr_ptr forward; the first eligible queue wins.
            for (int k = 0; k < NB_UNIT; k++) begin
                if (!grant_any && eligible[cand]) begin
                    grant_any = 1'b1;
                    win_idx   = cand;
                end
                cand = next_idx(cand);
            end
        end
    end

    assign grant           = grant_any ? idx_to_unit(win_idx) : UNIT_NONE;
    assign arithm_if.ready = grant[IDX_ARITHM];
    assign branch_if.ready = grant[IDX_BRANCH];
    assign lsu_if.ready    = grant[IDX_LSU];

    assign sb_set_v  = grant_any & head_rd_v[win_idx];
    assign sb_set_rd = head_rd[win_idx];

    // Next state
    always_comb begin
        issue_v_d    = issue_v_q;
        issue_unit_d = issue_unit_q;
        issue_rd_v_d = issue_rd_v_q;
        issue_rd_d   = issue_rd_q;
        issue_rs1_d  = issue_rs1_q;
        issue_rs2_d  = issue_rs2_q;

        if (flush_i) begin
            issue_v_d = 1'b0;
        end else if (slot_free) begin
            issue_v_d = grant_any;
            if (grant_any) begin
                issue_unit_d = grant;
                issue_rd_v_d = head_rd_v[win_idx];
                issue_rd_d   = head_rd[win_idx];
                issue_rs1_d  = head_rs1[win_idx];
                issue_rs2_d  = head_rs2[win_idx];
            end
        end
        // Otherwise the slot is stalled by exe and everything holds.

        rr_ptr_d = grant_any ? next_idx(win_idx) : rr_ptr_q;

        // Resolution or flush beats a same-cycle branch grant.
        if (flush_i || branch_done_i) begin
            branch_pending_d = 1'b0;
        end else if (grant[IDX_BRANCH]) begin
            branch_pending_d = 1'b1;
        end else begin
            branch_pending_d = branch_pending_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_v_q        <= 1'b0;
            issue_unit_q     <= '0;
            issue_rd_v_q     <= 1'b0;
            issue_rd_q       <= '0;
            issue_rs1_q      <= '0;
            issue_rs2_q      <= '0;
            rr_ptr_q         <= IDX_ARITHM;
            branch_pending_q <= 1'b0;
        end else begin
            issue_v_q        <= issue_v_d;
            issue_unit_q     <= issue_unit_d;
            issue_rd_v_q     <= issue_rd_v_d;
            issue_rd_q       <= issue_rd_d;
            issue_rs1_q      <= issue_rs1_d;
            issue_rs2_q      <= issue_rs2_d;
            rr_ptr_q         <= rr_ptr_d;
            branch_pending_q <= branch_pending_d;
        end
    end

    assign issue_v_o    = issue_v_q;
    assign issue_unit_o = issue_unit_q;
    assign issue_rd_v_o = issue_rd_v_q;
    assign issue_rd_o   = issue_rd_q;
    assign issue_rs1_o  = issue_rs1_q;
    assign issue_rs2_o  = issue_rs2_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
//   Directed stimulus with a scoreboard: every expected issue-slot packet is
//   pushed when its grant is expected and popped when exe accepts the slot.
//   Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             exe_ready_i = 1'b0;
    logic             wb_v_i = 1'b0;
    logic [REG_W-1:0] wb_rd_i = '0;
    logic             lsu_busy_i = 1'b0;
    logic             branch_done_i = 1'b0;
    logic             flush_i = 1'b0;
    logic             issue_v_o;
    logic [NB_UNIT-1:0] issue_unit_o;
    logic             issue_rd_v_o;
    logic [REG_W-1:0] issue_rd_o, issue_rs1_o, issue_rs2_o;

    issue_scheduler_if arithm_if ();
    issue_scheduler_if branch_if ();
    issue_scheduler_if lsu_if ();

    issue_scheduler dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arithm_if     (arithm_if),
        .branch_if     (branch_if),
        .lsu_if        (lsu_if),
        .exe_ready_i   (exe_ready_i),
        .wb_v_i        (wb_v_i),
        .wb_rd_i       (wb_rd_i),
        .lsu_busy_i    (lsu_busy_i),
        .branch_done_i (branch_done_i),
        .flush_i       (flush_i),
        .issue_v_o     (issue_v_o),
        .issue_unit_o  (issue_unit_o),
        .issue_rd_v_o  (issue_rd_v_o),
        .issue_rd_o    (issue_rd_o),
        .issue_rs1_o   (issue_rs1_o),
        .issue_rs2_o   (issue_rs2_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB_UNIT-1:0] unit;
        logic               rd_v;
        logic [REG_W-1:0]   rd;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t mon_act, mon_exp, drop;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input int exp);
        check(tag, 32'({lsu_if.ready, branch_if.ready, arithm_if.ready}), exp);
    endtask

    task automatic push(input unit_e u, input logic rd_v, input int rd, input int rs1, input int rs2);
        pkt_t p;
        p.unit = u;
        p.rd_v = rd_v;
        p.rd   = REG_W'(rd);
        p.rs1  = REG_W'(rs1);
        p.rs2  = REG_W'(rs2);
        exp_q.push_back(p);
    endtask

    task automatic set_head(input unit_idx_e u, input logic v,
                            input logic rs1_v, input int rs1,
                            input logic rs2_v, input int rs2,
                            input logic rd_v,  input int rd);
        case (u)
            IDX_ARITHM: begin
                arithm_if.v = v; arithm_if.rs1_v = rs1_v; arithm_if.rs1 = REG_W'(rs1);
                arithm_if.rs2_v = rs2_v; arithm_if.rs2 = REG_W'(rs2);
                arithm_if.rd_v = rd_v; arithm_if.rd = REG_W'(rd);
            end
            IDX_BRANCH: begin
                branch_if.v = v; branch_if.rs1_v = rs1_v; branch_if.rs1 = REG_W'(rs1);
                branch_if.rs2_v = rs2_v; branch_if.rs2 = REG_W'(rs2);
                branch_if.rd_v = rd_v; branch_if.rd = REG_W'(rd);
            end
            default: begin
                lsu_if.v = v; lsu_if.rs1_v = rs1_v; lsu_if.rs1 = REG_W'(rs1);
                lsu_if.rs2_v = rs2_v; lsu_if.rs2 = REG_W'(rs2);
                lsu_if.rd_v = rd_v; lsu_if.rd = REG_W'(rd);
            end
        endcase
    endtask

    function automatic logic sb_bit(input int r);
        return dut.u_scoreboard.busy_q[r];
    endfunction

    // Monitor: exe accepts the slot at the coming edge.
    always @(negedge clk) begin
        if (reset_n && issue_v_o && exe_ready_i) begin
            mon_act = '{issue_unit_o, issue_rd_v_o, issue_rd_o, issue_rs1_o, issue_rs2_o};
            if (exp_q.size() == 0) begin
                check("issue_unexpected", 32'(exp_q.size()), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("issue_pkt", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        set_head(IDX_ARITHM, 0, 0, 0, 0, 0, 0, 0);
        set_head(IDX_BRANCH, 0, 0, 0, 0, 0, 0, 0);
        set_head(IDX_LSU,    0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue_v", 32'(issue_v_o), 0);
        check("rst_fields", 32'({issue_unit_o, issue_rd_v_o, issue_rd_o, issue_rs1_o, issue_rs2_o}), 0);
        check("rst_sb", dut.u_scoreboard.busy_q, 0);
        check("rst_bp", 32'(dut.branch_pending_q), 0);
        check("rst_rr", 32'(dut.rr_ptr_q), 0);
        reset_n = 1'b1;
        exe_ready_i = 1'b1;

        // 1: basic arithm issue
        set_head(IDX_ARITHM, 1, 1, 1, 1, 2, 1, 3);
        @(negedge clk);
        chk_ready("t1_grant", 1);
        push(UNIT_ARITHM, 1, 3, 1, 2);
        tick();
        set_head(IDX_ARITHM, 0, 0, 0, 0, 0, 0, 0);
        check("t1_sb3", 32'(sb_bit(3)), 1);
        @(negedge clk);
        check("t1_issue_v", 32'(issue_v_o), 1);
        tick();
        check("t1_slot_empty", 32'(issue_v_o), 0);
        wb_v_i = 1'b1; wb_rd_i = 5'd3;
        tick();
        wb_v_i = 1'b0;
        check("t1_sb3_clr", 32'(sb_bit(3)), 0);

        // 2: RAW stall on rd=5 until writeback, bypass, set beats clear
        set_head(IDX_ARITHM, 1, 0, 0, 0, 0, 1, 5);
        @(negedge clk);
        chk_ready("t2_first", 1);
        push(UNIT_ARITHM, 1, 5, 0, 0);
        tick();
        set_head(IDX_ARITHM, 1, 1, 5, 0, 0, 1, 5);
        repeat (3) begin
            @(negedge clk);
            chk_ready("t2_stall", 0);
            check("t2_sb5", 32'(sb_bit(5)), 1);
            tick();
        end
        wb_v_i = 1'b1; wb_rd_i = 5'd5;
        @(negedge clk);
        chk_ready("t2_bypass", 1);
        push(UNIT_ARITHM, 1, 5, 5, 0);
        tick();
        wb_v_i = 1'b0;
        set_head(IDX_ARITHM, 0, 0, 0, 0, 0, 0, 0);
        check("t2_sb5_set_wins", 32'(sb_bit(5)), 1);
        check("t2_issue_v", 32'(issue_v_o), 1);

        // Asynchronous reset mid-operation
        reset_n = 1'b0;
        #1;
        check("rst2_issue_v", 32'(issue_v_o), 0);
        check("rst2_sb", dut.u_scoreboard.busy_q, 0);
        drop = exp_q.pop_back();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 3: round robin across all three queues
        set_head(IDX_ARITHM, 1, 1, 1, 1, 2, 0, 0);
        set_head(IDX_BRANCH, 1, 1, 3, 1, 4, 0, 0);
        set_head(IDX_LSU,    1, 1, 7, 1, 8, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (i)
                1: begin chk_ready("t3_rr_branch", 2); push(UNIT_BRANCH, 0, 0, 3, 4); end
                2: begin chk_ready("t3_rr_lsu", 4);    push(UNIT_LSU,    0, 0, 7, 8); end
                default: begin chk_ready("t3_rr_arithm", 1); push(UNIT_ARITHM, 0, 0, 1, 2); end
            endcase
            tick();
        end

        // 4: branch pending blocks second branch, lsu goes ahead
        set_head(IDX_ARITHM, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_ready("t4_lsu_while_bp", 4);
        check("t4_bp", 32'(dut.branch_pending_q), 1);
        push(UNIT_LSU, 0, 0, 7, 8);
        tick();
        set_head(IDX_LSU, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk);
            chk_ready("t4_br_stall", 0);
            tick();
        end
        branch_done_i = 1'b1;
        @(negedge clk);
        chk_ready("t4_done_cycle", 0);
        tick();
        branch_done_i = 1'b0;
        @(negedge clk);
        chk_ready("t4_br_grant", 2);
        push(UNIT_BRANCH, 0, 0, 3, 4);
        tick();
        set_head(IDX_BRANCH, 0, 0, 0, 0, 0, 0, 0);

        // 5: exe backpressure holds the slot, then lsu_busy honoured
        set_head(IDX_ARITHM, 1, 1, 9, 1, 10, 0, 0);
        @(negedge clk);
        chk_ready("t5_grant", 1);
        push(UNIT_ARITHM, 0, 0, 9, 10);
        tick();
        exe_ready_i = 1'b0;
        set_head(IDX_ARITHM, 0, 0, 0, 0, 0, 0, 0);
        set_head(IDX_LSU, 1, 1, 12, 1, 13, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk_ready("t5_hold_ready", 0);
            check("t5_hold_v", 32'(issue_v_o), 1);
            check("t5_hold_fields", 32'({issue_unit_o, issue_rs1_o, issue_rs2_o}),
                  32'({3'b001, 5'd9, 5'd10}));
            tick();
        end
        exe_ready_i = 1'b1;
        lsu_busy_i  = 1'b1;
        @(negedge clk);
        chk_ready("t5_lsu_busy", 0);
        tick();
        lsu_busy_i = 1'b0;
        @(negedge clk);
        chk_ready("t5_lsu_grant", 4);
        push(UNIT_LSU, 0, 0, 12, 13);
        tick();
        set_head(IDX_LSU, 0, 0, 0, 0, 0, 0, 0);

        // 6: flush with valid slot and pending branch
        set_head(IDX_ARITHM, 1, 0, 0, 0, 0, 1, 7);
        @(negedge clk);
        chk_ready("t6_grant", 1);
        push(UNIT_ARITHM, 1, 7, 0, 0);
        tick();
        exe_ready_i = 1'b0;
        flush_i = 1'b1;
        set_head(IDX_ARITHM, 1, 1, 11, 0, 0, 0, 0);
        @(negedge clk);
        chk_ready("t6_flush_nogrant", 0);
        check("t6_bp_before", 32'(dut.branch_pending_q), 1);
        tick();
        flush_i = 1'b0;
        exe_ready_i = 1'b1;
        drop = exp_q.pop_front();
        check("t6_issue_v", 32'(issue_v_o), 0);
        check("t6_bp_cleared", 32'(dut.branch_pending_q), 0);
        check("t6_sb7_kept", 32'(sb_bit(7)), 1);
        @(negedge clk);
        chk_ready("t6_regrant", 1);
        push(UNIT_ARITHM, 0, 0, 11, 0);
        tick();
        set_head(IDX_ARITHM, 0, 0, 0, 0, 0, 0, 0);
        set_head(IDX_BRANCH, 1, 1, 14, 1, 15, 0, 0);
        @(negedge clk);
        chk_ready("t6_branch_after_flush", 2);
        push(UNIT_BRANCH, 0, 0, 14, 15);
        tick();
        set_head(IDX_BRANCH, 0, 0, 0, 0, 0, 0, 0);
        wb_v_i = 1'b1; wb_rd_i = 5'd7;
        tick();
        wb_v_i = 1'b0;
        check("t6_sb7_clr", 32'(sb_bit(7)), 0);
        repeat (2) tick();

        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
